acumulador_moedas: RTL and testbench

Coin-credit accumulator and change dispenser for the vending-machine datapath. It accepts validated coin pulses, keeps the running credit in cents, and settles purchases. It returns change one coin per cycle. Its `centimos` output feeds the cents-to-euros display converter directly downstream.

---
 rtl/maquina_pkg.sv | 39 +++
 rtl/seletor_troco.sv | 24 ++
 rtl/acumulador_moedas.sv | 117 +++++++++++
 tb/tb_acumulador_moedas.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// Shared definitions for the vending-machine datapath: coin codes, credit limit, coin values, FSM states.
// Latency: none; constants, types and a pure combinational function.
// Backpressure: not applicable.
package maquina_pkg;

  // Coin codes as they arrive from the coin validator (0 and 7 are invalid).
  localparam logic [2:0] MOEDA_NENHUMA = 3'd0;
  localparam logic [2:0] MOEDA_5C      = 3'd1;
  localparam logic [2:0] MOEDA_10C     = 3'd2;
  localparam logic [2:0] MOEDA_20C     = 3'd3;
  localparam logic [2:0] MOEDA_50C     = 3'd4;
  localparam logic [2:0] MOEDA_100C    = 3'd5;
  localparam logic [2:0] MOEDA_200C    = 3'd6;

  // Default credit ceiling in cents; must fit 9 bits and be a multiple of 5.
  localparam int CREDITO_MAX_PADRAO = 500;

  // Accumulator states: taking credit, or paying change out coin by coin.
  typedef enum logic {
    CREDITO = 1'b0,
    TROCO   = 1'b1
  } estado_t;

  // Face value in cents of a coin code; invalid codes are worth nothing.
  function automatic logic [8:0] valor_moeda(input logic [2:0] codigo);
    logic [8:0] valor;
    case (codigo)
      MOEDA_5C:   valor = 9'd5;
      MOEDA_10C:  valor = 9'd10;
      MOEDA_20C:  valor = 9'd20;
      MOEDA_50C:  valor = 9'd50;
      MOEDA_100C: valor = 9'd100;
      MOEDA_200C: valor = 9'd200;
      default:    valor = 9'd0;
    endcase
    return valor;
  endfunction

endpackage

// File: rtl/seletor_troco.sv
// Greedy change selector: largest coin not exceeding the remaining amount, and its value.
// Latency: purely combinational.
// Backpressure: none; output follows the input every cycle.
module seletor_troco
  import maquina_pkg::*;
(
  input  logic [8:0] resto,
  output logic [2:0] codigo,
  output logic [8:0] valor
);

  // Walk the coin set from the largest value down; below 5c nothing can be paid.
  always_comb begin
    codigo = MOEDA_NENHUMA;
    if (resto >= 9'd200)      codigo = MOEDA_200C;
    else if (resto >= 9'd100) codigo = MOEDA_100C;
    else if (resto >= 9'd50)  codigo = MOEDA_50C;
    else if (resto >= 9'd20)  codigo = MOEDA_20C;
    else if (resto >= 9'd10)  codigo = MOEDA_10C;
    else if (resto >= 9'd5)   codigo = MOEDA_5C;
    valor = valor_moeda(codigo);
  end

endmodule

// File: rtl/acumulador_moedas.sv
// Coin-credit accumulator: adds accepted coins, settles purchases, returns change one coin per cycle.
// Latency: every response (credit, pulses, change coin) is registered, one cycle after its strobe.
// Backpressure: none; strobes are never stalled, ocupado marks the change phase where requests are refused.
module acumulador_moedas
  import maquina_pkg::*;
#(
  parameter int CREDITO_MAX = CREDITO_MAX_PADRAO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       moeda_valida,
  input  logic [2:0] moeda_tipo,
  input  logic       compra,
  input  logic [8:0] preco,
  input  logic       cancelar,
  output logic [8:0] centimos,
  output logic       moeda_rejeitada,
  output logic       venda_ok,
  output logic       compra_recusada,
  output logic       troco_moeda,
  output logic [2:0] troco_tipo,
  output logic       ocupado
);

  // Credit ceiling widened to the 10-bit sum width so the overflow compare cannot wrap.
  localparam logic [9:0] LIMITE = 10'(CREDITO_MAX);

  estado_t    estado;
  logic [8:0] valor_entrada;
  logic [9:0] soma;
  logic       moeda_aceite;
  logic       compra_aceite;
  logic [2:0] sel_codigo;
  logic [8:0] sel_valor;

  // Coin value, tentative new credit and acceptance tests for the current cycle.
  always_comb begin
    valor_entrada = valor_moeda(moeda_tipo);
    soma          = {1'b0, centimos} + {1'b0, valor_entrada};
    moeda_aceite  = (valor_entrada != 9'd0) && (soma <= LIMITE);
    compra_aceite = (preco != 9'd0) && ((preco % 9'd5) == 9'd0) && (preco <= centimos);
  end

  // Next change coin, chosen from the credit still owed.
  seletor_troco u_seletor_troco (
    .resto  (centimos),
    .codigo (sel_codigo),
    .valor  (sel_valor)
  );

  // FSM, credit register and all output pulses; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= CREDITO;
      centimos        <= 9'd0;
      moeda_rejeitada <= 1'b0;
      venda_ok        <= 1'b0;
      compra_recusada <= 1'b0;
      troco_moeda     <= 1'b0;
      troco_tipo      <= MOEDA_NENHUMA;
      ocupado         <= 1'b0;
    end else begin
      moeda_rejeitada <= 1'b0;
      venda_ok        <= 1'b0;
      compra_recusada <= 1'b0;
      troco_moeda     <= 1'b0;
      troco_tipo      <= MOEDA_NENHUMA;
      case (estado)
        CREDITO: begin
          if (cancelar) begin
            // Return everything; a coin arriving alongside is refused.
            if (centimos != 9'd0) begin
              estado  <= TROCO;
              ocupado <= 1'b1;
            end
            if (moeda_valida) moeda_rejeitada <= 1'b1;
          end else if (compra) begin
            if (compra_aceite) begin
              venda_ok <= 1'b1;
              centimos <= centimos - preco;
              // Exact payment leaves nothing to return.
              if (centimos != preco) begin
                estado  <= TROCO;
                ocupado <= 1'b1;
              end
            end else begin
              compra_recusada <= 1'b1;
            end
            if (moeda_valida) moeda_rejeitada <= 1'b1;
          end else if (moeda_valida) begin
            if (moeda_aceite) centimos <= soma[8:0];
            else              moeda_rejeitada <= 1'b1;
          end
        end
        TROCO: begin
          // Nothing is taken while paying out; cancelar has no meaning here.
          if (moeda_valida) moeda_rejeitada <= 1'b1;
          if (compra)       compra_recusada <= 1'b1;
          if (centimos == 9'd0) begin
            // One cycle after the last coin, drop back to taking credit.
            estado  <= CREDITO;
            ocupado <= 1'b0;
          end else begin
            troco_moeda <= 1'b1;
            troco_tipo  <= sel_codigo;
            centimos    <= centimos - sel_valor;
          end
        end
        default: begin
          estado  <= CREDITO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_moedas.sv
// Bench for acumulador_moedas: directed vector table, hand sequence for reset during change,
// then randomized traffic against a queue-based reference model of the credit/change rules.
module tb_acumulador_moedas;

  logic       clk;
  logic       rst_n;
  logic       moeda_valida;
  logic [2:0] moeda_tipo;
  logic       compra;
  logic [8:0] preco;
  logic       cancelar;
  logic [8:0] centimos;
  logic       moeda_rejeitada;
  logic       venda_ok;
  logic       compra_recusada;
  logic       troco_moeda;
  logic [2:0] troco_tipo;
  logic       ocupado;

  int n_cmp = 0;
  int n_err = 0;

  acumulador_moedas #(.CREDITO_MAX(500)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .moeda_valida    (moeda_valida),
    .moeda_tipo      (moeda_tipo),
    .compra          (compra),
    .preco           (preco),
    .cancelar        (cancelar),
    .centimos        (centimos),
    .moeda_rejeitada (moeda_rejeitada),
    .venda_ok        (venda_ok),
    .compra_recusada (compra_recusada),
    .troco_moeda     (troco_moeda),
    .troco_tipo      (troco_tipo),
    .ocupado         (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed cycle: inputs, then the outputs expected after the next edge.
  typedef struct {
    logic       mv;
    logic [2:0] mt;
    logic       cp;
    logic [8:0] pr;
    logic       cc;
    logic [8:0] e_cent;
    logic       e_rej;
    logic       e_ok;
    logic       e_rec;
    logic       e_tm;
    logic [2:0] e_tt;
    logic       e_oc;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic mv, input logic [2:0] mt, input logic cp,
                              input logic [8:0] pr, input logic cc, input logic [8:0] cent,
                              input logic rej, input logic ok, input logic rec,
                              input logic tm, input logic [2:0] tt, input logic oc);
    vec_t v;
    v.mv = mv; v.mt = mt; v.cp = cp; v.pr = pr; v.cc = cc;
    v.e_cent = cent; v.e_rej = rej; v.e_ok = ok; v.e_rec = rec;
    v.e_tm = tm; v.e_tt = tt; v.e_oc = oc;
    return v;
  endfunction

  function automatic logic [16:0] saidas();
    return {centimos, moeda_rejeitada, venda_ok, compra_recusada, troco_moeda, troco_tipo, ocupado};
  endfunction

  task automatic chk(input string nome, input logic [16:0] esperado);
    logic [16:0] real_v;
    real_v = saidas();
    n_cmp++;
    if (real_v !== esperado) begin
      n_err++;
      $display("FAIL %s: got cent=%0d rej=%0b ok=%0b rec=%0b tm=%0b tt=%0d oc=%0b, want cent=%0d rej=%0b ok=%0b rec=%0b tm=%0b tt=%0d oc=%0b",
               nome, real_v[16:8], real_v[7], real_v[6], real_v[5], real_v[4], real_v[3:1], real_v[0],
               esperado[16:8], esperado[7], esperado[6], esperado[5], esperado[4], esperado[3:1], esperado[0]);
    end
  endtask

  task automatic aplicar(input logic mv, input logic [2:0] mt, input logic cp,
                         input logic [8:0] pr, input logic cc);
    moeda_valida = mv; moeda_tipo = mt; compra = cp; preco = pr; cancelar = cc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Credit as an integer; on entering change the whole greedy coin list is queued up front,
  // then one queued coin leaves per cycle, plus one trailing busy cycle once the queue is empty.
  int m_cred;
  bit m_busy;
  int m_q[$];

  function automatic int valor_de(input int codigo);
    case (codigo)
      1: return 5;
      2: return 10;
      3: return 20;
      4: return 50;
      5: return 100;
      6: return 200;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_cred = 0;
    m_busy = 1'b0;
    m_q.delete();
  endtask

  task automatic m_inicia_troco();
    int r;
    r = m_cred;
    for (int c = 6; c >= 1; c--) begin
      while (r >= valor_de(c)) begin
        m_q.push_back(c);
        r -= valor_de(c);
      end
    end
    m_busy = 1'b1;
  endtask

  task automatic m_passo(input logic mv, input logic [2:0] mt, input logic cp,
                         input logic [8:0] pr, input logic cc, output logic [16:0] esp);
    logic rej, ok, rec, tm;
    int tt, v, c;
    rej = 0; ok = 0; rec = 0; tm = 0; tt = 0;
    if (m_busy) begin
      rej = mv;
      rec = cp;
      if (m_q.size() > 0) begin
        c = m_q.pop_front();
        tm = 1; tt = c;
        m_cred -= valor_de(c);
      end else begin
        m_busy = 1'b0;
      end
    end else if (cc) begin
      rej = mv;
      if (m_cred > 0) m_inicia_troco();
    end else if (cp) begin
      rej = mv;
      if (pr != 0 && (int'(pr) % 5) == 0 && int'(pr) <= m_cred) begin
        ok = 1;
        m_cred -= int'(pr);
        if (m_cred > 0) m_inicia_troco();
      end else begin
        rec = 1;
      end
    end else if (mv) begin
      v = valor_de(int'(mt));
      if (v != 0 && m_cred + v <= 500) m_cred += v;
      else rej = 1;
    end
    esp = {9'(m_cred), rej, ok, rec, tm, 3'(tt), m_busy};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [16:0] esp;
    logic mv, cp, cc;
    logic [2:0] mt;
    logic [8:0] pr;
    string nome;

    moeda_valida = 0; moeda_tipo = 0; compra = 0; preco = 0; cancelar = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset", 17'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //          mv mt  cp pr   cc  cent rej ok rec tm tt oc
    tab.push_back(mk(1, 6, 0, 0,   0, 200, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 5, 0, 0,   0, 300, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 3, 0, 0,   0, 320, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 135, 0, 185, 0, 1, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,  85, 0, 0, 0, 1, 5, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,  35, 0, 0, 0, 1, 4, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,  15, 0, 0, 0, 1, 3, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,   5, 0, 0, 0, 1, 2, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,   0, 0, 0, 0, 1, 1, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 6, 0, 0,   0, 200, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 6, 0, 0,   0, 400, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 3, 0, 0,   0, 420, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4, 0, 0,   0, 470, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 2, 0, 0,   0, 480, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4, 0, 0,   0, 480, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 7, 0, 0,   0, 480, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 0, 0,   0, 480, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 2, 0, 0,   0, 490, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 2, 0, 0,   0, 500, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 0, 0,   0, 500, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,   1, 500, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0,   0, 300, 0, 0, 0, 1, 6, 1));
    tab.push_back(mk(0, 0, 0, 0,   0, 100, 0, 0, 0, 1, 6, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,   0, 0, 0, 0, 1, 5, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 5, 0, 0,   0, 100, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 150, 0, 100, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 33,  0, 100, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0,   0, 100, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 100, 0,   0, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 4, 0, 0,   0,  50, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 3, 0, 0,   0,  70, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 5,   1,  70, 1, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 1, 1, 5,   0,  20, 1, 0, 1, 1, 4, 1));
    tab.push_back(mk(0, 0, 0, 0,   1,   0, 0, 0, 0, 1, 3, 1));
    tab.push_back(mk(0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0));

    foreach (tab[i]) begin
      aplicar(tab[i].mv, tab[i].mt, tab[i].cp, tab[i].pr, tab[i].cc);
      nome = $sformatf("vec%0d", i);
      chk(nome, {tab[i].e_cent, tab[i].e_rej, tab[i].e_ok, tab[i].e_rec,
                 tab[i].e_tm, tab[i].e_tt, tab[i].e_oc});
    end

    // Reset while the second change coin is being shown.
    aplicar(1, 5, 0, 0, 0); chk("rst_seq_c100", {9'd100, 8'b0000_0000});
    aplicar(1, 3, 0, 0, 0); chk("rst_seq_c20",  {9'd120, 8'b0000_0000});
    aplicar(1, 2, 0, 0, 0); chk("rst_seq_c10",  {9'd130, 8'b0000_0000});
    aplicar(0, 0, 0, 0, 1); chk("rst_seq_cancel", {9'd130, 8'b0000_0001});
    aplicar(0, 0, 0, 0, 0); chk("rst_seq_coin1", {9'd30, 4'b0001, 3'd5, 1'b1});
    aplicar(0, 0, 0, 0, 0); chk("rst_seq_coin2", {9'd10, 4'b0001, 3'd3, 1'b1});
    #2 rst_n = 1'b0;
    #1 chk("rst_async_clear", 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    aplicar(0, 0, 0, 0, 0); chk("rst_after_idle", 17'd0);
    aplicar(1, 1, 0, 0, 0); chk("rst_after_coin", {9'd5, 8'b0000_0000});

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      mv = ($urandom_range(0, 99) < 50);
      mt = 3'($urandom_range(0, 7));
      cp = ($urandom_range(0, 99) < 15);
      cc = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 1) == 1) pr = 9'(5 * $urandom_range(0, m_cred / 5 + 1));
      else                           pr = 9'($urandom_range(0, 511));
      m_passo(mv, mt, cp, pr, cc, esp);
      aplicar(mv, mt, cp, pr, cc);
      nome = $sformatf("rand%0d", k);
      chk(nome, esp);
    end

    moeda_valida = 0; compra = 0; cancelar = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
